// File: rtl/alu_pkg.sv
// Shared definitions for the FP16 sample loader.
//   - FP16 field widths/positions and exponent bias
//   - default frame depth and fixed-point fraction width
//   - loader state encoding
package alu_pkg;

   localparam int FP16_W        = 16;
   localparam int FP16_SIGN_POS = 15;
   localparam int FP16_EXP_W    = 5;
   localparam int FP16_EXP_LSB  = 10;
   localparam int FP16_MANT_W   = 10;
   localparam int FP16_MANT_LSB = 0;
   localparam int FP16_EXP_BIAS = 15;

   localparam int DEFAULT_DEPTH     = 64;
   localparam int DEFAULT_FRAC_BITS = 15;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_e;

endpackage

// File: rtl/fp16_to_fx.sv
// Combinational FP16 -> signed 16-bit fixed-point converter.
//   fp_in   : IEEE half-precision {sign, exp[4:0], mant[9:0]}
//   fx_out  : signed fixed-point result with FRAC_BITS fractional bits
//   clamped : result was forced to full scale (always for Inf; for
//             out-of-range finite values only when saturation is built in)
// Build option: define FP_SAMPLE_LOADER_SAT_EN to clamp out-of-range finite
// values to 16'h7FFF / 16'h8000; otherwise the low 16 bits of the
// two's-complement result are passed through.
module fp16_to_fx
   import alu_pkg::*;
#(
   parameter int FRAC_BITS = DEFAULT_FRAC_BITS
) (
   input  logic [15:0] fp_in,
   output logic [15:0] fx_out,
   output logic        clamped
);

   // value = 1.mant * 2^(exp-bias); the significand is an 11-bit integer
   // already scaled by 2^MANT_W, hence the combined offset.
   localparam int SHIFT_OFS = FRAC_BITS - FP16_EXP_BIAS - FP16_MANT_W;

`ifdef FP_SAMPLE_LOADER_SAT_EN
   localparam int MAG_W   = 48;
   localparam int MAX_LSH = MAG_W - FP16_MANT_W - 1;
`else
   // Wrap mode only ever needs the low 16 bits of the magnitude.
   localparam int MAG_W   = 16;
`endif

   logic                   sign;
   logic [FP16_EXP_W-1:0]  exp_f;
   logic [FP16_MANT_W-1:0] mant;
   logic [MAG_W-1:0]       sig_w;
   logic [MAG_W-1:0]       mag;
   logic [15:0]            wrap;
   int                     sh;

   assign sign  = fp_in[FP16_SIGN_POS];
   assign exp_f = fp_in[FP16_EXP_LSB +: FP16_EXP_W];
   assign mant  = fp_in[FP16_MANT_LSB +: FP16_MANT_W];
   assign sig_w = MAG_W'({1'b1, mant});
   assign sh    = int'(exp_f) + SHIFT_OFS;

   always_comb begin
      mag = '0;
      if (sh >= 0) begin
         mag = sig_w << sh;
      end else begin
         mag = sig_w >> (-sh);
      end
      // Low 16 bits of the negation equal the negation of the low 16 bits.
      wrap = sign ? (~mag[15:0] + 16'd1) : mag[15:0];
   end

`ifdef FP_SAMPLE_LOADER_SAT_EN
   logic ovf;
   // Negative full scale (-32768) is representable, positive is not.
   assign ovf = (sh > MAX_LSH) ||
                (sign ? (mag > MAG_W'(32768)) : (mag > MAG_W'(32767)));
`endif

   always_comb begin
      fx_out  = wrap;
      clamped = 1'b0;
      if (exp_f == '0) begin
         fx_out = '0;
      end else if (exp_f == '1) begin
         if (mant != '0) begin
            fx_out = '0;
         end else begin
            fx_out  = sign ? 16'h8000 : 16'h7FFF;
            clamped = 1'b1;
         end
      end
`ifdef FP_SAMPLE_LOADER_SAT_EN
      else if (ovf) begin
         fx_out  = sign ? 16'h8000 : 16'h7FFF;
         clamped = 1'b1;
      end
`endif
   end

endmodule

// File: rtl/fp_sample_loader.sv
// Loads a frame of DEPTH FP16 samples, converts each to signed fixed point
// and holds the frame for a consumer until it is released.
//   clk, reset_n  : clock (rising edge), asynchronous active-low reset
//   in_valid/in_fp/in_ready : FP16 sample stream, accepted on valid && ready
//   frame_valid   : DEPTH converted samples are held in the buffer
//   frame_ack     : consumer releases the frame (ignored while filling)
//   rd_addr/rd_data : buffer read port, one cycle latency
//   sat_cnt       : clamped samples in the current frame
// Build option: FP_SAMPLE_LOADER_SAT_EN selects clamping of out-of-range
// finite samples in the converter (see fp16_to_fx).
//
// state | meaning
// FILL  | accepting samples, writing converted values into the buffer
// HOLD  | frame complete, buffer frozen until frame_ack
module fp_sample_loader
   import alu_pkg::*;
#(
   parameter int DEPTH     = DEFAULT_DEPTH,
   parameter int FRAC_BITS = DEFAULT_FRAC_BITS
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     in_valid,
   input  logic [15:0]              in_fp,
   output logic                     in_ready,
   output logic                     frame_valid,
   input  logic                     frame_ack,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [15:0]              rd_data,
   output logic [$clog2(DEPTH):0]   sat_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

   state_e         state_q, state_d;
   logic [CW-1:0]  acc_cnt_q, acc_cnt_d;
   logic [CW-1:0]  sat_cnt_q, sat_cnt_d;
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [15:0]    stage_q, stage_d;
   logic           stage_vld_q, stage_vld_d;
   logic           frame_valid_q, frame_valid_d;
   logic [15:0]    rd_data_q, rd_data_d;
   logic           accept;
   logic           wr_en;
   logic [15:0]    fx_val;
   logic           fx_clamped;
   logic [15:0]    buf_mem [DEPTH];

   fp16_to_fx #(
      .FRAC_BITS (FRAC_BITS)
   ) u_conv (
      .fp_in   (stage_q),
      .fx_out  (fx_val),
      .clamped (fx_clamped)
   );

   // Gated by reset_n so in_ready reads 0 during reset yet is high in the
   // very first cycle after release.
   assign in_ready    = reset_n && (state_q == FILL) && (acc_cnt_q != FULL_CNT);
   assign accept      = in_valid && in_ready;
   assign frame_valid = frame_valid_q;
   assign rd_data     = rd_data_q;
   assign sat_cnt     = sat_cnt_q;

   always_comb begin
      state_d       = state_q;
      acc_cnt_d     = acc_cnt_q;
      sat_cnt_d     = sat_cnt_q;
      wr_ptr_d      = wr_ptr_q;
      stage_d       = stage_q;
      stage_vld_d   = 1'b0;
      frame_valid_d = frame_valid_q;
      wr_en         = stage_vld_q;
      rd_data_d     = buf_mem[rd_addr];

      if (state_q == FILL) begin
         if (accept) begin
            stage_d     = in_fp;
            stage_vld_d = 1'b1;
            acc_cnt_d   = acc_cnt_q + 1'b1;
         end
         if (stage_vld_q) begin
            if (fx_clamped && (sat_cnt_q != FULL_CNT)) begin
               sat_cnt_d = sat_cnt_q + 1'b1;
            end
            if (wr_ptr_q == LAST_PTR) begin
               frame_valid_d = 1'b1;
               state_d       = HOLD;
            end else begin
               wr_ptr_d = wr_ptr_q + 1'b1;
            end
         end
      end else begin
         if (frame_ack) begin
            frame_valid_d = 1'b0;
            wr_ptr_d      = '0;
            acc_cnt_d     = '0;
            sat_cnt_d     = '0;
            state_d       = FILL;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= FILL;
         acc_cnt_q     <= '0;
         sat_cnt_q     <= '0;
         wr_ptr_q      <= '0;
         stage_q       <= '0;
         stage_vld_q   <= 1'b0;
         frame_valid_q <= 1'b0;
         rd_data_q     <= '0;
      end else begin
         state_q       <= state_d;
         acc_cnt_q     <= acc_cnt_d;
         sat_cnt_q     <= sat_cnt_d;
         wr_ptr_q      <= wr_ptr_d;
         stage_q       <= stage_d;
         stage_vld_q   <= stage_vld_d;
         frame_valid_q <= frame_valid_d;
         rd_data_q     <= rd_data_d;
      end
   end

   // Buffer contents survive reset; they are only meaningful with frame_valid.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         buf_mem[wr_ptr_q] <= fx_val;
      end
   end

endmodule

// File: tb/tb_fp_sample_loader.sv
// Directed testbench for fp_sample_loader (DEPTH=64, FRAC_BITS=15).
// Expected values follow from hand analysis of the FP16 encodings; the
// build option FP_SAMPLE_LOADER_SAT_EN selects the saturating expectations.
module tb_fp_sample_loader;

   localparam int DEPTH = 64;
`ifdef FP_SAMPLE_LOADER_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_fp = '0;
   logic        frame_ack = 1'b0;
   logic [5:0]  rd_addr = '0;
   logic        in_ready;
   logic        frame_valid;
   logic [15:0] rd_data;
   logic [6:0]  sat_cnt;

   int checks = 0;
   int errors = 0;

   logic [15:0] fa_fp [DEPTH];
   logic [15:0] fa_exp[DEPTH];
   logic [15:0] fb_fp [DEPTH];
   logic [15:0] fb_exp[DEPTH];
   logic [15:0] fc_fp [DEPTH];
   logic [15:0] fc_exp[DEPTH];

   always #5 clk = ~clk;

   fp_sample_loader #(
      .DEPTH     (DEPTH),
      .FRAC_BITS (15)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .in_fp       (in_fp),
      .in_ready    (in_ready),
      .frame_valid (frame_valid),
      .frame_ack   (frame_ack),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .sat_cnt     (sat_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int gaps;

      // Frame A: special values first, then 0.5..~1.0 (exp 14 -> shift 4)
      for (int k = 0; k < DEPTH; k++) begin
         fa_fp[k]  = {(k % 2 == 1), 5'd14, 10'(k * 16)};
         fa_exp[k] = (k % 2 == 1) ? 16'(-(16384 + 256 * k)) : 16'(16384 + 256 * k);
      end
      fa_fp[0] = 16'h3800;  fa_exp[0] = 16'h4000;
      fa_fp[1] = 16'hB800;  fa_exp[1] = 16'hC000;
      fa_fp[2] = 16'hBC00;  fa_exp[2] = 16'h8000;
      fa_fp[3] = 16'h0001;  fa_exp[3] = 16'h0000;
      fa_fp[4] = 16'h7E00;  fa_exp[4] = 16'h0000;
      fa_fp[5] = 16'h3C00;  fa_exp[5] = SAT ? 16'h7FFF : 16'h8000;
      fa_fp[6] = 16'hFC00;  fa_exp[6] = 16'h8000;
      // Frame B: exp 13 -> shift 3, sign from bit 1 of the index
      for (int k = 0; k < DEPTH; k++) begin
         fb_fp[k]  = {((k / 2) % 2 == 1), 5'd13, 10'(k * 8)};
         fb_exp[k] = ((k / 2) % 2 == 1) ? 16'(-(8192 + 64 * k)) : 16'(8192 + 64 * k);
      end
      // Frame C: exp 12 -> shift 2
      for (int k = 0; k < DEPTH; k++) begin
         fc_fp[k]  = {1'b0, 5'd12, 10'(k * 4)};
         fc_exp[k] = 16'(4096 + 16 * k);
      end

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_frame_valid", 32'(frame_valid), 0);
      chk("rst_rd_data", 32'(rd_data), 0);
      chk("rst_sat_cnt", 32'(sat_cnt), 0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("rel_in_ready", 32'(in_ready), 1);
      tick();

      // Frame A: back-to-back stream
      for (int k = 0; k < DEPTH; k++) begin
         in_valid = 1'b1;
         in_fp    = fa_fp[k];
         if (k == 0 || k == 63) chk("a_ready_pre", 32'(in_ready), 1);
         tick();
         if (k == 5) chk("a_sat_after_nan", 32'(sat_cnt), 0);
         if (k == 6) chk("a_sat_after_one", 32'(sat_cnt), SAT ? 1 : 0);
         if (k == 7) chk("a_sat_after_ninf", 32'(sat_cnt), SAT ? 2 : 1);
      end
      chk("a_ready_after_64", 32'(in_ready), 0);
      chk("a_fv_at_accept_64", 32'(frame_valid), 0);
      in_fp = 16'h7C00;
      tick();
      chk("a_fv_one_edge_later", 32'(frame_valid), 1);
      chk("a_sat_final", 32'(sat_cnt), SAT ? 2 : 1);
      n = 0;
      repeat (20) begin
         tick();
         if (in_ready !== 1'b0 || frame_valid !== 1'b1) n++;
      end
      chk("a_hold_stable", 32'(n), 0);
      chk("a_hold_sat", 32'(sat_cnt), SAT ? 2 : 1);
      in_valid = 1'b0;
      for (int a = 0; a < DEPTH; a++) begin
         rd_addr = 6'(a);
         tick();
         chk($sformatf("a_rd[%0d]", a), 32'(rd_data), 32'(fa_exp[a]));
      end
      rd_addr = 6'd5;
      #1;
      chk("a_rd_latency_old", 32'(rd_data), 32'(fa_exp[63]));
      tick();
      chk("a_rd_latency_new", 32'(rd_data), 32'(fa_exp[5]));

      frame_ack = 1'b1;
      tick();
      frame_ack = 1'b0;
      chk("a_ack_ready", 32'(in_ready), 1);
      chk("a_ack_fv", 32'(frame_valid), 0);
      chk("a_ack_sat", 32'(sat_cnt), 0);

      // Frame B: random gaps, junk +Inf offered while in_valid is low
      for (int k = 0; k < DEPTH; k++) begin
         gaps     = int'($urandom_range(0, 3));
         in_valid = 1'b0;
         in_fp    = 16'h7C00;
         repeat (gaps) tick();
         in_valid = 1'b1;
         in_fp    = fb_fp[k];
         tick();
      end
      in_fp = 16'h7C00;
      n = 0;
      while (frame_valid !== 1'b1 && n < 5) begin
         tick();
         n++;
      end
      chk("b_fv", 32'(frame_valid), 1);
      chk("b_fv_latency", 32'(n), 1);
      repeat (20) tick();
      chk("b_hold_ready", 32'(in_ready), 0);
      chk("b_hold_sat", 32'(sat_cnt), 0);
      in_valid = 1'b0;
      for (int a = 0; a < DEPTH; a++) begin
         rd_addr = 6'(a);
         tick();
         chk($sformatf("b_rd[%0d]", a), 32'(rd_data), 32'(fb_exp[a]));
      end
      frame_ack = 1'b1;
      tick();
      frame_ack = 1'b0;
      chk("b_ack_ready", 32'(in_ready), 1);

      // Frame C: partial fill with one +Inf, then reset mid-fill
      for (int k = 0; k < 30; k++) begin
         in_valid = 1'b1;
         in_fp    = (k == 2) ? 16'h7C00 : fc_fp[k];
         tick();
      end
      in_valid = 1'b0;
      tick();
      chk("c_sat_before_rst", 32'(sat_cnt), 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("c_rst_ready", 32'(in_ready), 0);
      chk("c_rst_fv", 32'(frame_valid), 0);
      chk("c_rst_sat", 32'(sat_cnt), 0);
      chk("c_rst_rd_data", 32'(rd_data), 0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("c_rel_ready", 32'(in_ready), 1);
      tick();
      for (int k = 0; k < DEPTH; k++) begin
         in_valid  = 1'b1;
         in_fp     = fc_fp[k];
         frame_ack = (k == 10 || k == 40);
         tick();
         if (k == 62) chk("c_fv_after_63", 32'(frame_valid), 0);
      end
      frame_ack = 1'b0;
      in_valid  = 1'b0;
      chk("c_fv_at_accept_64", 32'(frame_valid), 0);
      tick();
      chk("c_fv", 32'(frame_valid), 1);
      rd_addr = 6'd0;
      tick();
      chk("c_rd[0]", 32'(rd_data), 32'(fc_exp[0]));
      rd_addr = 6'd30;
      tick();
      chk("c_rd[30]", 32'(rd_data), 32'(fc_exp[30]));
      rd_addr = 6'd63;
      tick();
      chk("c_rd[63]", 32'(rd_data), 32'(fc_exp[63]));
      chk("c_sat", 32'(sat_cnt), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
